// File: rtl/recon_sum_p.sv
// recon_sum_p: reconstruction adder for one 4x4 block.
// Adds a signed residual to the intra, inter (L0) or bi-predictive (L0/L1
// average) prediction, clips to [0, 2^BIT_DEPTH-1] and registers the 16
// reconstructed samples. LANES samples are produced per enabled cycle, so a
// block takes 16/LANES beats, followed by a one-cycle write request.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous reset, active HIGH (1 = reset)
//   ena                 clock enable; 0 freezes all state and outputs
//   start               begin a block (accepted in IDLE only)
//   mb_pred_mode        macroblock prediction mode, latched at start
//   bipred              average L0/L1 prediction, latched at start
//   residual            16 x (BIT_DEPTH+1) two's complement residuals
//   intra_pred          16 x BIT_DEPTH intra prediction samples
//   inter_pred_l0/l1    16 x BIT_DEPTH inter prediction samples
//   sum                 registered reconstruction, sample k at [k*W +: W]
//   sum_right_colum     samples 3,7,11,15 (sample 3 in LSBs)
//   sum_bottom_row      samples 12..15 (sample 12 in LSBs)
//   write_to_ram_start  one-cycle request to the RAM writer
//   write_to_ram_valid  RAM writer done
//   valid               block reconstructed and written
//   busy                block in progress
module recon_sum_p #(
   parameter int unsigned BIT_DEPTH = 8,
   parameter int unsigned LANES     = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic                           start,
   input  logic [3:0]                     mb_pred_mode,
   input  logic                           bipred,
   input  logic [16*(BIT_DEPTH+1)-1:0]    residual,
   input  logic [16*BIT_DEPTH-1:0]        intra_pred,
   input  logic [16*BIT_DEPTH-1:0]        inter_pred_l0,
   input  logic [16*BIT_DEPTH-1:0]        inter_pred_l1,
   output logic [16*BIT_DEPTH-1:0]        sum,
   output logic [4*BIT_DEPTH-1:0]         sum_right_colum,
   output logic [4*BIT_DEPTH-1:0]         sum_bottom_row,
   output logic                           write_to_ram_start,
   input  logic                           write_to_ram_valid,
   output logic                           valid,
   output logic                           busy
);

   localparam int unsigned W  = BIT_DEPTH;
   localparam int unsigned RW = BIT_DEPTH + 1;
   localparam int unsigned SW = BIT_DEPTH + 2;
   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   // Mode codes mirror the mb_pred_mode_* values of defines.v.
   localparam logic [3:0] MB_PRED_MODE_PRED_L0 = 4'd0;
   localparam logic [3:0] MB_PRED_MODE_P_REF0  = 4'd3;
   localparam logic [3:0] MB_PRED_MODE_P_SKIP  = 4'd4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SUM   = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]      state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [3:0]      mode_q, mode_nxt;
   logic            bipred_q, bipred_nxt;
   logic [16*W-1:0] sum_nxt;
   logic            wrs_nxt;
   logic            valid_nxt;
   logic            busy_nxt;

   logic            use_inter;
   logic            skip;
   logic            last_beat;

   logic [RW-1:0]   lane_res   [LANES];
   logic [W-1:0]    lane_intra [LANES];
   logic [W-1:0]    lane_l0    [LANES];
   logic [W-1:0]    lane_l1    [LANES];
   logic [W-1:0]    lane_sum   [LANES];

   // Add a residual to a prediction and clip to the sample range. The sum
   // fits W+2 bits: sign bit set means negative, bit W set means overflow.
   function automatic logic [W-1:0] clip_add(input logic [RW-1:0] res,
                                              input logic [W-1:0]  pred);
      logic [SW-1:0] s;
      s = {res[RW-1], res} + {2'b00, pred};
      if (s[SW-1])
         clip_add = '0;
      else if (s[W])
         clip_add = '1;
      else
         clip_add = s[W-1:0];
   endfunction

   // Rounded L0/L1 average; the W+1 bit sum cannot overflow.
   function automatic logic [W-1:0] bi_avg(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [RW-1:0] t;
      t = {1'b0, a} + {1'b0, b} + RW'(1);
      bi_avg = t[W:1];
   endfunction

   assign use_inter = (mode_q == MB_PRED_MODE_PRED_L0) ||
                      (mode_q == MB_PRED_MODE_P_REF0)  ||
                      (mode_q == MB_PRED_MODE_P_SKIP);
   assign skip      = (mode_q == MB_PRED_MODE_P_SKIP);
   assign last_beat = (cnt == CW'(N - 1));

   // Route the samples of the current beat onto the lane datapath.
   always_comb begin : p_lane_mux
      for (int l = 0; l < int'(LANES); l++) begin
         lane_res[l]   = '0;
         lane_intra[l] = '0;
         lane_l0[l]    = '0;
         lane_l1[l]    = '0;
         for (int c = 0; c < int'(N); c++) begin
            if (cnt == CW'(c)) begin
               lane_res[l]   = residual[(c*int'(LANES)+l)*int'(RW) +: RW];
               lane_intra[l] = intra_pred[(c*int'(LANES)+l)*int'(W) +: W];
               lane_l0[l]    = inter_pred_l0[(c*int'(LANES)+l)*int'(W) +: W];
               lane_l1[l]    = inter_pred_l1[(c*int'(LANES)+l)*int'(W) +: W];
            end
         end
      end
   end

   // Per-lane prediction select and clipped add.
   always_comb begin : p_lane_calc
      for (int l = 0; l < int'(LANES); l++) begin
         logic [W-1:0]  pred;
         logic [RW-1:0] res;
         if (use_inter)
            pred = bipred_q ? bi_avg(lane_l0[l], lane_l1[l]) : lane_l0[l];
         else
            pred = lane_intra[l];
         res = skip ? '0 : lane_res[l];
         lane_sum[l] = clip_add(res, pred);
      end
   end

   // Next-state and next-output logic.
   always_comb begin : p_next
      state_nxt  = state;
      cnt_nxt    = cnt;
      mode_nxt   = mode_q;
      bipred_nxt = bipred_q;
      sum_nxt    = sum;
      wrs_nxt    = write_to_ram_start;
      valid_nxt  = valid;
      case (state)
         IDLE: begin
            if (start) begin
               mode_nxt   = mb_pred_mode;
               bipred_nxt = bipred;
               cnt_nxt    = '0;
               valid_nxt  = 1'b0;
               state_nxt  = SUM;
            end
         end
         SUM: begin
            for (int k = 0; k < 16; k++) begin
               if (cnt == CW'(k / int'(LANES)))
                  sum_nxt[k*int'(W) +: W] = lane_sum[k % int'(LANES)];
            end
            if (last_beat) begin
               wrs_nxt   = 1'b1;
               state_nxt = WRITE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         WRITE: begin
            // The request cycle itself never sees the writer's answer.
            if (write_to_ram_start) begin
               wrs_nxt = 1'b0;
            end else if (write_to_ram_valid) begin
               valid_nxt = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers; ena low holds everything.
   always_ff @(posedge clk or posedge rst_n) begin : p_regs
      if (rst_n) begin
         state              <= IDLE;
         cnt                <= '0;
         mode_q             <= '0;
         bipred_q           <= 1'b0;
         sum                <= '0;
         write_to_ram_start <= 1'b0;
         valid              <= 1'b0;
         busy               <= 1'b0;
      end else if (ena) begin
         state              <= state_nxt;
         cnt                <= cnt_nxt;
         mode_q             <= mode_nxt;
         bipred_q           <= bipred_nxt;
         sum                <= sum_nxt;
         write_to_ram_start <= wrs_nxt;
         valid              <= valid_nxt;
         busy               <= busy_nxt;
      end
   end

   // Neighbour outputs are plain taps of the registered block.
   assign sum_right_colum = {sum[15*W +: W], sum[11*W +: W], sum[7*W +: W], sum[3*W +: W]};
   assign sum_bottom_row  = {sum[15*W +: W], sum[14*W +: W], sum[13*W +: W], sum[12*W +: W]};

endmodule

// File: tb/tb_recon_sum_p.sv
// tb_recon_sum_p: directed bench for recon_sum_p (W=8/LANES=4 main instance
// plus W=10 instances with LANES 1, 2, 8, 16).
module tb_recon_sum_p;

   localparam logic [3:0] M_PRED_L0 = 4'd0;
   localparam logic [3:0] M_P_SKIP  = 4'd4;
   localparam logic [3:0] M_I4MB    = 4'd5;

   function automatic int lanes_of(input int g);
      case (g)
         0:       lanes_of = 1;
         1:       lanes_of = 2;
         2:       lanes_of = 8;
         default: lanes_of = 16;
      endcase
   endfunction

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ena = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   mb_pred_mode = '0;
   logic         bipred = 1'b0;
   logic [143:0] residual = '0;
   logic [127:0] intra_pred = '0;
   logic [127:0] inter_pred_l0 = '0;
   logic [127:0] inter_pred_l1 = '0;
   logic [127:0] sum;
   logic [31:0]  sum_right_colum;
   logic [31:0]  sum_bottom_row;
   logic         wrs;
   logic         wrv = 1'b0;
   logic         valid;
   logic         busy;

   logic         ena10 = 1'b1;
   logic         start10 = 1'b0;
   logic [3:0]   mode10 = '0;
   logic         bip10 = 1'b0;
   logic         wrv10 = 1'b0;
   logic [175:0] res10 = '0;
   logic [159:0] pred10 = '0;
   logic [159:0] sum10 [4];
   logic [39:0]  rc10  [4];
   logic [39:0]  br10  [4];
   logic         wrs10 [4];
   logic         val10 [4];
   logic         busy10[4];

   int errors = 0;
   int checks = 0;
   bit stall  = 1'b0;

   always #5 clk = ~clk;

   recon_sum_p #(.BIT_DEPTH(8), .LANES(4)) u_dut (
      .clk                (clk),
      .rst_n              (rst),
      .ena                (ena),
      .start              (start),
      .mb_pred_mode       (mb_pred_mode),
      .bipred             (bipred),
      .residual           (residual),
      .intra_pred         (intra_pred),
      .inter_pred_l0      (inter_pred_l0),
      .inter_pred_l1      (inter_pred_l1),
      .sum                (sum),
      .sum_right_colum    (sum_right_colum),
      .sum_bottom_row     (sum_bottom_row),
      .write_to_ram_start (wrs),
      .write_to_ram_valid (wrv),
      .valid              (valid),
      .busy               (busy)
   );

   for (genvar g = 0; g < 4; g++) begin : g_sweep
      recon_sum_p #(.BIT_DEPTH(10), .LANES(lanes_of(g))) u_w10 (
         .clk                (clk),
         .rst_n              (rst),
         .ena                (ena10),
         .start              (start10),
         .mb_pred_mode       (mode10),
         .bipred             (bip10),
         .residual           (res10),
         .intra_pred         (pred10),
         .inter_pred_l0      (pred10),
         .inter_pred_l1      (pred10),
         .sum                (sum10[g]),
         .sum_right_colum    (rc10[g]),
         .sum_bottom_row     (br10[g]),
         .write_to_ram_start (wrs10[g]),
         .write_to_ram_valid (wrv10),
         .valid              (val10[g]),
         .busy               (busy10[g])
      );
   end

   // Advance one clock; in stall mode ena alternates every cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      if (stall) ena = ~ena;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic set_uniform(input int ip, input int l0, input int l1, input int r);
      for (int k = 0; k < 16; k++) begin
         intra_pred[k*8 +: 8]    = 8'(ip);
         inter_pred_l0[k*8 +: 8] = 8'(l0);
         inter_pred_l1[k*8 +: 8] = 8'(l1);
         residual[k*9 +: 9]      = 9'(r);
      end
   endtask

   // One unstalled block on the main instance; optionally holds start high
   // together with write_to_ram_valid throughout WRITE.
   task automatic run_block(input logic [3:0] mode, input logic bip,
                            input bit start_in_write, input string tag);
      int lat;
      mb_pred_mode = mode;
      bipred       = bip;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " busy"}, 256'(busy), 256'(1));
      lat = 0;
      while (!wrs && lat < 40) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, 256'(lat), 256'(4));
      wrv = 1'b1;
      if (start_in_write) start = 1'b1;
      tick();
      check({tag, " req one cycle"}, 256'(wrs), 256'(0));
      check({tag, " no early valid"}, 256'(valid), 256'(0));
      tick();
      wrv   = 1'b0;
      start = 1'b0;
      check({tag, " valid"}, 256'(valid), 256'(1));
      check({tag, " idle"}, 256'(busy), 256'(0));
   endtask

   initial begin : main
      logic [127:0] exp;
      logic [127:0] pat_exp;
      logic [159:0] exp10;
      int lat10 [4];
      int lat, n;
      bit saw_req;

      // Reset state
      tick();
      tick();
      check("rst sum", 256'(sum), 256'(0));
      check("rst req", 256'(wrs), 256'(0));
      check("rst valid", 256'(valid), 256'(0));
      check("rst busy", 256'(busy), 256'(0));
      rst = 1'b0;
      tick();

      // Intra 100 + 20 -> 120
      set_uniform(100, 0, 0, 20);
      run_block(M_I4MB, 1'b0, 1'b0, "intra");
      for (int k = 0; k < 16; k++) exp[k*8 +: 8] = 8'd120;
      check("intra sum", 256'(sum), 256'(exp));

      // Clipping, four groups; start held with the writer answer in WRITE
      for (int k = 0; k < 16; k++) begin
         case (k / 4)
            0: begin intra_pred[k*8 +: 8] = 8'd250; residual[k*9 +: 9] = 9'd10;  exp[k*8 +: 8] = 8'd255; end
            1: begin intra_pred[k*8 +: 8] = 8'd5;   residual[k*9 +: 9] = 9'h1EC; exp[k*8 +: 8] = 8'd0;   end
            2: begin intra_pred[k*8 +: 8] = 8'd0;   residual[k*9 +: 9] = 9'h0FF; exp[k*8 +: 8] = 8'd255; end
            default: begin intra_pred[k*8 +: 8] = 8'd255; residual[k*9 +: 9] = 9'h100; exp[k*8 +: 8] = 8'd0; end
         endcase
      end
      run_block(M_I4MB, 1'b0, 1'b1, "clip");
      check("clip sum", 256'(sum), 256'(exp));
      tick();
      check("start in write ignored", 256'(busy), 256'(0));

      // P_SKIP ignores residual and intra
      set_uniform(200, 64, 0, 77);
      run_block(M_P_SKIP, 1'b0, 1'b0, "pskip");
      for (int k = 0; k < 16; k++) exp[k*8 +: 8] = 8'd64;
      check("pskip sum", 256'(sum), 256'(exp));

      // Bi-pred: (10+13+1)>>1 = 12, minus 2 -> 10
      set_uniform(200, 10, 13, -2);
      run_block(M_PRED_L0, 1'b1, 1'b0, "bipred");
      for (int k = 0; k < 16; k++) exp[k*8 +: 8] = 8'd10;
      check("bipred sum", 256'(sum), 256'(exp));

      // Distinct samples: pred 4k, residual k-8 -> max(0, 5k-8)
      for (int k = 0; k < 16; k++) begin
         intra_pred[k*8 +: 8] = 8'(4*k);
         residual[k*9 +: 9]   = 9'(k-8);
         pat_exp[k*8 +: 8]    = (5*k-8 < 0) ? 8'd0 : 8'(5*k-8);
      end
      run_block(M_I4MB, 1'b0, 1'b0, "pattern");
      check("pattern sum", 256'(sum), 256'(pat_exp));
      check("right column", 256'(sum_right_colum), 256'(32'h432F1B07));
      check("bottom row", 256'(sum_bottom_row), 256'(32'h433E3934));

      // W=10 lane sweep, writer answering immediately
      for (int k = 0; k < 16; k++) begin
         pred10[k*10 +: 10] = 10'(4*k);
         res10[k*11 +: 11]  = 11'(k-8);
         exp10[k*10 +: 10]  = (5*k-8 < 0) ? 10'd0 : 10'(5*k-8);
      end
      mode10  = M_I4MB;
      start10 = 1'b1;
      tick();
      start10 = 1'b0;
      wrv10   = 1'b1;
      for (int i = 0; i < 4; i++) lat10[i] = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         for (int i = 0; i < 4; i++)
            if (wrs10[i] && lat10[i] == 0) lat10[i] = cyc;
      end
      wrv10 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("w10 lanes%0d latency", lanes_of(i)), 256'(lat10[i]), 256'(16 / lanes_of(i)));
         check($sformatf("w10 lanes%0d sum", lanes_of(i)), 256'(sum10[i]), 256'(exp10));
         check($sformatf("w10 lanes%0d valid", lanes_of(i)), 256'(val10[i]), 256'(1));
      end
      check("w10 right column", 256'(rc10[3]), 256'({10'd67, 10'd47, 10'd27, 10'd7}));

      // Reset during SUM beat 2
      set_uniform(100, 0, 0, 20);
      mb_pred_mode = M_I4MB;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("midrst sum", 256'(sum), 256'(0));
      check("midrst req", 256'(wrs), 256'(0));
      check("midrst valid", 256'(valid), 256'(0));
      check("midrst busy", 256'(busy), 256'(0));
      tick();
      tick();
      rst = 1'b0;
      saw_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (wrs) saw_req = 1'b1;
      end
      check("midrst no request", 256'(saw_req), 256'(0));
      run_block(M_I4MB, 1'b0, 1'b0, "after rst");
      for (int k = 0; k < 16; k++) exp[k*8 +: 8] = 8'd120;
      check("after rst sum", 256'(sum), 256'(exp));

      // Stalled run with extra start while busy
      for (int k = 0; k < 16; k++) begin
         intra_pred[k*8 +: 8] = 8'(4*k);
         residual[k*9 +: 9]   = 9'(k-8);
      end
      ena   = 1'b1;
      stall = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      lat = 4;
      while (!wrs && lat < 60) begin
         tick();
         lat++;
      end
      check("stall latency", 256'(lat), 256'(8));
      tick();
      check("stall req stretched", 256'(wrs), 256'(1));
      wrv = 1'b1;
      n = 0;
      while (!valid && n < 20) begin
         tick();
         n++;
      end
      wrv = 1'b0;
      check("stall valid delay", 256'(n), 256'(3));
      check("stall sum", 256'(sum), 256'(pat_exp));
      stall = 1'b0;
      ena   = 1'b1;
      tick();
      tick();
      check("stall extra start ignored", 256'(busy), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
